// File: rtl/io_regs_pkg.sv
// Register map and factor bit positions for the 0xFxx timer/interrupt I/O block.
// Shared by the block itself and the top-level data-bus decode.
package io_regs_pkg;

    localparam logic [11:0] ADDR_IT    = 12'hF00;
    localparam logic [11:0] ADDR_IPT   = 12'hF02;
    localparam logic [11:0] ADDR_EIT   = 12'hF10;
    localparam logic [11:0] ADDR_EIPT  = 12'hF12;
    localparam logic [11:0] ADDR_TM_LO = 12'hF20;
    localparam logic [11:0] ADDR_TM_HI = 12'hF21;
    localparam logic [11:0] ADDR_PD_LO = 12'hF24;
    localparam logic [11:0] ADDR_PD_HI = 12'hF25;
    localparam logic [11:0] ADDR_RD_LO = 12'hF26;
    localparam logic [11:0] ADDR_RD_HI = 12'hF27;
    localparam logic [11:0] ADDR_TMRST = 12'hF76;
    localparam logic [11:0] ADDR_PTCTL = 12'hF78;

    localparam int unsigned IT_32HZ   = 0;
    localparam int unsigned IT_8HZ    = 1;
    localparam int unsigned IT_2HZ    = 2;
    localparam int unsigned IT_1HZ    = 3;
    localparam int unsigned PTCTL_RUN = 0;
    localparam int unsigned PTCTL_RST = 1;

    // Clock-timer factors raised when TM has just advanced to n.
    function automatic logic [3:0] clk_factors(input logic [7:0] n);
        logic [3:0] f;
        f          = '0;
        f[IT_32HZ] = (n[2:0] == 3'd0);
        f[IT_8HZ]  = (n[4:0] == 5'd0);
        f[IT_2HZ]  = (n[6:0] == 7'd0);
        f[IT_1HZ]  = (n == 8'd0);
        return f;
    endfunction

endpackage

// File: rtl/prog_timer.sv
// 8-bit programmable down-timer: PD counts down on ticks while running and reloads from RD,
// pulsing uflow_o on the 1 -> reload step.
module prog_timer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       run_i,
    input  logic       load_i,
    input  logic       rd_lo_we_i,
    input  logic       rd_hi_we_i,
    input  logic [3:0] wdata_i,
    output logic [7:0] pd_o,
    output logic [7:0] rd_o,
    output logic       uflow_o
);

    logic [7:0] pd_q, pd_d;
    logic [7:0] rd_q, rd_d;

    always_comb begin
        rd_d    = rd_q;
        pd_d    = pd_q;
        uflow_o = 1'b0;
        if (rd_lo_we_i) rd_d[3:0] = wdata_i;
        if (rd_hi_we_i) rd_d[7:4] = wdata_i;
        // A software load beats a coincident tick and suppresses the factor.
        if (load_i) begin
            pd_d = rd_q;
        end else if (tick_i && run_i) begin
            if (pd_q == 8'd1) begin
                pd_d    = rd_q;
                uflow_o = 1'b1;
            end else begin
                pd_d = pd_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pd_q <= '0;
            rd_q <= '0;
        end else begin
            pd_q <= pd_d;
            rd_q <= rd_d;
        end
    end

    assign pd_o = pd_q;
    assign rd_o = rd_q;

endmodule

// File: rtl/io_timer_interrupt.sv
// Clock timer, programmable timer, interrupt factor/mask registers and the CPU interrupt
// request, mapped into the 0xFxx data-bus segment with a registered read port.
module io_timer_interrupt
    import io_regs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_256hz,
    input  logic [11:0] memory_addr,
    input  logic        memory_write_en,
    input  logic [3:0]  memory_write_data,
    output logic [3:0]  memory_read_data,
    output logic        interrupt_req
);

    logic [7:0] tm_q, tm_d, tm_inc;
    logic [3:0] it_q, it_d, it_set, eit_q, eit_d;
    logic       ipt_q, ipt_d, eipt_q, eipt_d, ptrun_q, ptrun_d;
    logic [3:0] rdata_q, rdata_d;
    logic       irq_q, irq_d;
    logic [7:0] pd, rd;
    logic       pt_uflow, rd_en, tmrst, ptrst;

    function automatic logic wr_at(input logic [11:0] a);
        return memory_write_en && (memory_addr == a);
    endfunction

    assign rd_en = !memory_write_en && (memory_addr[11:8] == 4'hF);
    assign tmrst = wr_at(ADDR_TMRST) && memory_write_data[0];
    assign ptrst = wr_at(ADDR_PTCTL) && memory_write_data[PTCTL_RST];

    prog_timer u_prog_timer (
        .clk_i      (clk),
        .rst_i      (reset),
        .tick_i     (tick_256hz),
        .run_i      (ptrun_q),
        .load_i     (ptrst),
        .rd_lo_we_i (wr_at(ADDR_RD_LO)),
        .rd_hi_we_i (wr_at(ADDR_RD_HI)),
        .wdata_i    (memory_write_data),
        .pd_o       (pd),
        .rd_o       (rd),
        .uflow_o    (pt_uflow)
    );

    always_comb begin
        tm_inc = tm_q + 8'd1;
        tm_d   = tm_q;
        it_set = '0;
        if (tmrst) begin
            tm_d = '0;
        end else if (tick_256hz) begin
            tm_d   = tm_inc;
            it_set = clk_factors(tm_inc);
        end
        // W1C clears first so a coincident set survives.
        it_d    = (it_q & ~(wr_at(ADDR_IT) ? memory_write_data : 4'h0)) | it_set;
        ipt_d   = (ipt_q & ~(wr_at(ADDR_IPT) & memory_write_data[0])) | pt_uflow;
        eit_d   = wr_at(ADDR_EIT) ? memory_write_data : eit_q;
        eipt_d  = wr_at(ADDR_EIPT) ? memory_write_data[0] : eipt_q;
        ptrun_d = wr_at(ADDR_PTCTL) ? memory_write_data[PTCTL_RUN] : ptrun_q;
        irq_d   = (|(it_q & eit_q)) | (ipt_q & eipt_q);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (memory_addr)
                ADDR_IT:    rdata_d = it_q;
                ADDR_IPT:   rdata_d = {3'b000, ipt_q};
                ADDR_EIT:   rdata_d = eit_q;
                ADDR_EIPT:  rdata_d = {3'b000, eipt_q};
                ADDR_TM_LO: rdata_d = tm_q[3:0];
                ADDR_TM_HI: rdata_d = tm_q[7:4];
                ADDR_PD_LO: rdata_d = pd[3:0];
                ADDR_PD_HI: rdata_d = pd[7:4];
                ADDR_RD_LO: rdata_d = rd[3:0];
                ADDR_RD_HI: rdata_d = rd[7:4];
                ADDR_PTCTL: rdata_d = {3'b000, ptrun_q};
                default:    rdata_d = 4'h0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tm_q    <= '0;
            it_q    <= '0;
            eit_q   <= '0;
            ipt_q   <= 1'b0;
            eipt_q  <= 1'b0;
            ptrun_q <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            tm_q    <= tm_d;
            it_q    <= it_d;
            eit_q   <= eit_d;
            ipt_q   <= ipt_d;
            eipt_q  <= eipt_d;
            ptrun_q <= ptrun_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign memory_read_data = rdata_q;
    assign interrupt_req    = irq_q;

endmodule
